// File: rtl/mdu_pkg.sv
// Shared op codes and FSM state type for the iterative multiply/divide unit.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/mdu_iter_core.sv
// One iteration of the shared engine: shift-add multiply step or restoring divide step.
module mdu_iter_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] acc_next_c,
    output logic [WIDTH-1:0] q_next_c
);

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;

    always_comb begin
        addend     = q[0] ? m : {WIDTH{1'b0}};
        sum        = {1'b0, acc} + {1'b0, addend};
        rem_sh     = {acc, q[WIDTH-1]};
        diff       = rem_sh - {1'b0, m};
        acc_next_c = sum[WIDTH:1];
        q_next_c   = {sum[0], q[WIDTH-1:1]};
        if (div) begin
            // Top bit of diff set means the shifted remainder was below the divisor.
            if (!diff[WIDTH]) begin
                acc_next_c = diff[WIDTH-1:0];
                q_next_c   = {q[WIDTH-2:0], 1'b1};
            end else begin
                acc_next_c = rem_sh[WIDTH-1:0];
                q_next_c   = {q[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers; WIDTH+2 cycles per mult/div.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH);

    state_t                 state, state_nx;
    logic [CW-1:0]          cnt;
    logic [WIDTH-1:0]       acc, qr, mr;
    logic [WIDTH-1:0]       acc_nx, q_nx;
    logic                   is_div, neg_q, neg_r, dz;
    logic                   accept_c, md_start_c, sgn_c;
    logic [WIDTH-1:0]       a_sel_c, b_sel_c;
    logic [2*WIDTH-1:0]     prod_c;
    logic [WIDTH-1:0]       quo_c, rem_c;

    mdu_iter_core #(.WIDTH(WIDTH)) u_core (
        .div        (is_div),
        .acc        (acc),
        .q          (qr),
        .m          (mr),
        .acc_next_c (acc_nx),
        .q_next_c   (q_nx)
    );

    // Operand conditioning and final sign correction
    always_comb begin
        accept_c   = start && (state == IDLE);
        md_start_c = accept_c && (op <= MDU_DIVU);
        sgn_c      = !op[0];
        a_sel_c    = (sgn_c && a[WIDTH-1]) ? -a : a;
        b_sel_c    = (sgn_c && b[WIDTH-1]) ? -b : b;
        prod_c     = neg_q ? -{acc, qr} : {acc, qr};
        quo_c      = dz ? {WIDTH{1'b1}} : (neg_q ? -qr : qr);
        rem_c      = neg_r ? -acc : acc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (md_start_c) state_nx = RUN;
            RUN:     if (cnt == '0) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc    <= '0;
            qr     <= '0;
            mr     <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            busy <= (state_nx != IDLE);
            done <= (state == FIX);
            if (md_start_c) begin
                acc    <= '0;
                qr     <= op[1] ? a_sel_c : b_sel_c;
                mr     <= op[1] ? b_sel_c : a_sel_c;
                cnt    <= CW'(WIDTH - 1);
                is_div <= op[1];
                neg_q  <= sgn_c && (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r  <= sgn_c && op[1] && a[WIDTH-1];
                dz     <= op[1] && (b == '0);
            end else if (accept_c && op == MDU_MTHI) begin
                hi <= a;
            end else if (accept_c && op == MDU_MTLO) begin
                lo <= a;
            end
            if (state == RUN) begin
                acc <= acc_nx;
                qr  <= q_nx;
                cnt <= cnt - CW'(1);
            end
            // Divide by zero leaves |a| in the remainder; dividend-sign fix restores a.
            if (state == FIX) begin
                if (is_div) begin
                    hi <= rem_c;
                    lo <= quo_c;
                end else begin
                    hi <= prod_c[2*WIDTH-1:WIDTH];
                    lo <= prod_c[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomised + directed bench for mul_div_unit against a transaction-level HI/LO model.
module tb_mul_div_unit;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference result {hi, lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, p, q, r;
        logic [63:0] u;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            3'd0: begin p = sx * sy; return 64'(p); end
            3'd1: begin u = {32'd0, x} * {32'd0, y}; return u; end
            3'd2: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            3'd3: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            default: return 64'd0;
        endcase
    endfunction

    // Model: a mult/div occupies W+1 busy cycles, then results land with a done pulse.
    int          left;
    logic [31:0] m_hi, m_lo;
    logic        m_done;
    logic [63:0] pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left   <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_done <= 1'b0;
            pend   <= '0;
        end else begin
            m_done <= 1'b0;
            if (left > 0) begin
                left <= left - 1;
                if (left == 1) begin
                    m_hi   <= pend[63:32];
                    m_lo   <= pend[31:0];
                    m_done <= 1'b1;
                end
            end else if (start) begin
                if (op <= 3'd3) begin
                    pend <= ref_result(op, a, b);
                    left <= W + 1;
                end else if (op == 3'd4) begin
                    m_hi <= a;
                end else if (op == 3'd5) begin
                    m_lo <= a;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(left != 0));
        check("done", 32'(done), 32'(m_done));
        check("hi",   hi, m_hi);
        check("lo",   lo, m_lo);
    end

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(15));
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge; presents a one-cycle start and returns at the next negedge.
    task automatic start_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, output int t0);
        t0    = cyc;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        op    = 3'($urandom);
        a     = $urandom;
        b     = $urandom;
    endtask

    // Waits (bounded) for done, optionally pulsing stray starts while busy.
    task automatic wait_done(input int t0, input int noise_pct);
        int n;
        n = 0;
        while (!done && n < 60) begin
            start = ($urandom_range(99) < noise_pct);
            op    = 3'($urandom);
            a     = $urandom;
            b     = $urandom;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("latency", done ? 32'(cyc - t0) : 32'hFFFF_FFFF, 32'd34);
    endtask

    initial begin
        int t0;
        int seen;
        logic [2:0]  o;
        logic [31:0] x, y;

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        @(posedge clk); #3 rst_n = 1'b1;
        @(negedge clk);

        start_op(3'd1, 32'hFFFF_FFFF, 32'd2, t0);
        wait_done(t0, 0);
        check("multu_hi", hi, 32'h0000_0001);
        check("multu_lo", lo, 32'hFFFF_FFFE);

        start_op(3'd0, 32'hFFFF_FFFD, 32'd5, t0);
        wait_done(t0, 0);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFF1);

        start_op(3'd2, 32'hFFFF_FFF9, 32'd2, t0);
        wait_done(t0, 0);
        check("div_hi", hi, 32'hFFFF_FFFF);
        check("div_lo", lo, 32'hFFFF_FFFD);

        start_op(3'd3, 32'd7, 32'd0, t0);
        wait_done(t0, 0);
        check("divz_hi", hi, 32'd7);
        check("divz_lo", lo, 32'hFFFF_FFFF);

        // Back-to-back: issued in the done cycle.
        start_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, t0);
        wait_done(t0, 0);
        check("ovf_hi", hi, 32'd0);
        check("ovf_lo", lo, 32'h8000_0000);

        // Stray DIVU while busy must be ignored.
        start_op(3'd1, 32'd3, 32'd4, t0);
        repeat (9) @(negedge clk);
        start = 1'b1; op = 3'd3; a = 32'd9; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done(t0, 0);
        check("busy_ign_hi", hi, 32'd0);
        check("busy_ign_lo", lo, 32'd12);
        start_op(3'd4, 32'h1234, 32'd0, t0);
        check("mthi_hi", hi, 32'h1234);
        check("mthi_lo", lo, 32'd12);

        // Reset mid-operation.
        start_op(3'd2, 32'd100, 32'd7, t0);
        while (cyc < t0 + 10) @(negedge clk);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_hi", hi, 32'd0);
        check("mid_rst_lo", lo, 32'd0);
        @(posedge clk); #3 rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("no_done_after_rst", 32'(seen), 32'd0);
        start_op(3'd1, 32'd6, 32'd7, t0);
        wait_done(t0, 0);
        check("post_rst_hi", hi, 32'd0);
        check("post_rst_lo", lo, 32'd42);

        // Random traffic with stray starts during busy periods.
        repeat (60) begin
            o = 3'($urandom_range(7));
            x = pick_operand();
            y = pick_operand();
            start_op(o, x, y, t0);
            if (o <= 3'd3) wait_done(t0, 15);
        end
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
